// File: rtl/aes_256_unroll7_ctr_sched.sv
// Batch scheduler / CTR controller for a 7-stage unrolled AES-256 round pipeline.
// Runs each batch through the pipeline twice (key_sel 0 then 1) and streams out pt ^ keystream.
module aes_256_unroll7_ctr_sched #(
  parameter int BLOCK_SIZE = 128,
  parameter int PIPE_DEPTH = 7
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ctr_load,
  input  logic [BLOCK_SIZE-1:0] ctr_init,
  input  logic [BLOCK_SIZE-1:0] round_key_0,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [BLOCK_SIZE-1:0] in_data,
  input  logic                  in_last,
  output logic [BLOCK_SIZE-1:0] pipe_in,
  output logic                  key_sel,
  input  logic [BLOCK_SIZE-1:0] pipe_out,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [BLOCK_SIZE-1:0] out_data,
  output logic                  busy
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    COLLECT = 3'd1,
    PASS1   = 3'd2,
    PASS2   = 3'd3,
    DRAIN   = 3'd4
  } state_t;

  state_t                  state_r, state_nx_s;
  logic [3:0]              n_r, n_nx_s;
  logic [3:0]              p_r, p_nx_s;
  logic [3:0]              last_p_s;
  logic [BLOCK_SIZE-1:0]   ctr_r, ctr_eff_s;
  logic [BLOCK_SIZE-1:0]   pt_buf_r [PIPE_DEPTH];
  logic [BLOCK_SIZE-1:0]   ks_buf_r [PIPE_DEPTH];
  logic [BLOCK_SIZE-1:0]   pipe_in_r, pipe_in_nx_s;
  logic [BLOCK_SIZE-1:0]   out_data_r, out_data_nx_s;
  logic [BLOCK_SIZE-1:0]   ks_rd_s;
  logic                    key_sel_r, out_valid_r;
  logic                    in_ready_s, accept_s;
  logic                    cap_s, issue1_s, issue2_s;
  logic [2:0]              cap_idx_s, rd_idx_s, pt_wr_idx_s;

  assign in_ready_s  = (state_r == IDLE) || (state_r == COLLECT);
  assign accept_s    = in_valid && in_ready_s;
  assign last_p_s    = n_r + 4'(PIPE_DEPTH - 1);
  assign cap_s       = ((state_r == PASS1) || (state_r == PASS2)) && (p_r >= 4'(PIPE_DEPTH));
  assign cap_idx_s   = 3'(p_r - 4'(PIPE_DEPTH));
  assign pt_wr_idx_s = (state_r == COLLECT) ? n_r[2:0] : 3'd0;
  assign ctr_eff_s   = ((state_r == IDLE) && ctr_load) ? ctr_init : ctr_r;

  assign in_ready  = in_ready_s;
  assign busy      = (state_r != IDLE);
  assign pipe_in   = pipe_in_r;
  assign key_sel   = key_sel_r;
  assign out_valid = out_valid_r;
  assign out_data  = out_data_r;

  // FSM state, batch size and pass/drain index registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      n_r     <= 4'd0;
      p_r     <= 4'd0;
    end else begin
      state_r <= state_nx_s;
      n_r     <= n_nx_s;
      p_r     <= p_nx_s;
    end
  end

  // Next-state logic; p counts pass cycles in PASS1/PASS2 and the output index in DRAIN
  always_comb begin
    state_nx_s = state_r;
    n_nx_s     = n_r;
    p_nx_s     = p_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          n_nx_s     = 4'd1;
          p_nx_s     = 4'd0;
          state_nx_s = in_last ? PASS1 : COLLECT;
        end else begin
          n_nx_s = 4'd0;
        end
      end
      COLLECT: begin
        if (accept_s) begin
          n_nx_s = n_r + 4'd1;
          p_nx_s = 4'd0;
          if (in_last || (n_r == 4'(PIPE_DEPTH - 1))) begin
            state_nx_s = PASS1;
          end else begin
            state_nx_s = COLLECT;
          end
        end else begin
          state_nx_s = COLLECT;
        end
      end
      PASS1, PASS2: begin
        if (p_r == last_p_s) begin
          p_nx_s     = 4'd0;
          state_nx_s = (state_r == PASS1) ? PASS2 : DRAIN;
        end else begin
          p_nx_s = p_r + 4'd1;
        end
      end
      DRAIN: begin
        if (out_valid_r && out_ready) begin
          if (p_r == (n_r - 4'd1)) begin
            state_nx_s = IDLE;
            n_nx_s     = 4'd0;
            p_nx_s     = 4'd0;
          end else begin
            p_nx_s = p_r + 4'd1;
          end
        end else begin
          p_nx_s = p_r;
        end
      end
      default: begin
        state_nx_s = IDLE;
        n_nx_s     = 4'd0;
        p_nx_s     = 4'd0;
      end
    endcase
  end

  assign issue1_s = (state_nx_s == PASS1) && (p_nx_s < n_nx_s);
  assign issue2_s = (state_nx_s == PASS2) && (p_nx_s < n_nx_s);
  assign rd_idx_s = (p_nx_s < 4'(PIPE_DEPTH)) ? p_nx_s[2:0] : 3'd0;

  // Keystream read with bypass: the slot being captured this cycle may be the one read next
  always_comb begin
    if (cap_s && (cap_idx_s == rd_idx_s)) begin
      ks_rd_s = pipe_out;
    end else begin
      ks_rd_s = ks_buf_r[rd_idx_s];
    end
  end

  // Output lookahead: registered outputs are loaded with the value for the next cycle
  always_comb begin
    pipe_in_nx_s  = {BLOCK_SIZE{1'b0}};
    out_data_nx_s = out_data_r;
    if (issue1_s) begin
      pipe_in_nx_s = ctr_eff_s ^ round_key_0;
    end else if (issue2_s) begin
      pipe_in_nx_s = ks_rd_s;
    end else begin
      pipe_in_nx_s = {BLOCK_SIZE{1'b0}};
    end
    if (state_nx_s == DRAIN) begin
      out_data_nx_s = pt_buf_r[rd_idx_s] ^ ks_rd_s;
    end else begin
      out_data_nx_s = out_data_r;
    end
  end

  // Counter, buffers and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctr_r       <= {BLOCK_SIZE{1'b0}};
      pipe_in_r   <= {BLOCK_SIZE{1'b0}};
      key_sel_r   <= 1'b0;
      out_valid_r <= 1'b0;
      out_data_r  <= {BLOCK_SIZE{1'b0}};
      for (int i = 0; i < PIPE_DEPTH; i++) begin
        pt_buf_r[i] <= {BLOCK_SIZE{1'b0}};
        ks_buf_r[i] <= {BLOCK_SIZE{1'b0}};
      end
    end else begin
      if (issue1_s) begin
        ctr_r <= ctr_eff_s + BLOCK_SIZE'(1'b1);
      end else if ((state_r == IDLE) && ctr_load) begin
        ctr_r <= ctr_init;
      end else begin
        ctr_r <= ctr_r;
      end
      if (accept_s) begin
        pt_buf_r[pt_wr_idx_s] <= in_data;
      end
      if (cap_s) begin
        ks_buf_r[cap_idx_s] <= pipe_out;
      end
      pipe_in_r   <= pipe_in_nx_s;
      key_sel_r   <= (state_nx_s == PASS2) || (state_nx_s == DRAIN);
      out_valid_r <= (state_nx_s == DRAIN);
      out_data_r  <= out_data_nx_s;
    end
  end

endmodule

// File: tb/tb_aes_256_unroll7_ctr_sched.sv
// Bench for aes_256_unroll7_ctr_sched: a toy 7-cycle round pipeline feeds pipe_out,
// the driver queues expected ciphertext and a negedge monitor compares each handshake.
module tb_aes_256_unroll7_ctr_sched;

  localparam logic [127:0] K1 = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
  localparam logic [127:0] K2 = 128'hA5A5_5A5A_0F0F_F0F0_3C3C_C3C3_9696_6969;
  localparam logic [127:0] R0 = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
  localparam logic [127:0] JUNK = 128'hDEAD_BEEF_DEAD_BEEF_DEAD_BEEF_DEAD_BEEF;

  logic         clk = 1'b0;
  logic         rst;
  logic         ctr_load;
  logic [127:0] ctr_init, round_key_0, in_data, pipe_in, pipe_out, out_data;
  logic         in_valid, in_ready, in_last, key_sel, out_valid, out_ready, busy;

  int vec = 0;
  int mis = 0;
  int cyc = 0;
  int hs_cnt = 0;
  logic [127:0] sb_q [$];
  logic [127:0] model_ctr;
  logic [128:0] sr [7];
  logic         hold_pend = 1'b0;
  logic [127:0] prev_data;

  aes_256_unroll7_ctr_sched dut (
    .clk(clk), .rst(rst), .ctr_load(ctr_load), .ctr_init(ctr_init),
    .round_key_0(round_key_0), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last), .pipe_in(pipe_in), .key_sel(key_sel),
    .pipe_out(pipe_out), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Toy pipeline: pass with key_sel=0 adds K1, with key_sel=1 XORs K2; 7-cycle latency
  always @(posedge clk) begin
    sr[0] <= {key_sel, pipe_in};
    for (int i = 1; i < 7; i++) sr[i] <= sr[i-1];
  end
  assign pipe_out = sr[6][128] ? (sr[6][127:0] ^ K2) : (sr[6][127:0] + K1);

  function automatic logic [127:0] exp_ct(logic [127:0] c, logic [127:0] rk, logic [127:0] pt);
    return (((c ^ rk) + K1) ^ K2) ^ pt;
  endfunction

  task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
    vec++;
    if (act !== exp) begin
      mis++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: score every output handshake and check data holds under back-pressure
  always @(negedge clk) begin
    if (rst) begin
      hold_pend = 1'b0;
    end else begin
      if (hold_pend) chk("hold", out_data, prev_data);
      hold_pend = out_valid && !out_ready;
      prev_data = out_data;
      if (out_valid && out_ready) begin
        hs_cnt++;
        if (sb_q.size() == 0) chk("unexpected_out_valid", 128'd1, 128'd0);
        else chk("ciphertext", out_data, sb_q.pop_front());
      end
    end
  end

  task automatic at_cyc(int t);
    if (cyc > t) chk("schedule_late", 128'(cyc), 128'(t));
    while (cyc < t) @(negedge clk);
  endtask

  task automatic send(logic [127:0] d, logic last, output int c);
    int guard = 0;
    in_valid = 1'b1; in_data = d; in_last = last;
    @(negedge clk);
    while (!in_ready && guard < 300) begin
      guard++;
      @(negedge clk);
    end
    if (!in_ready) chk("in_ready_timeout", 128'd0, 128'd1);
    c = cyc;
    sb_q.push_back(exp_ct(model_ctr, round_key_0, d));
    model_ctr = model_ctr + 128'd1;
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic wait_idle();
    int guard = 0;
    @(negedge clk);
    while (busy && guard < 300) begin
      guard++;
      @(negedge clk);
    end
    chk("idle_busy", 128'(busy), 128'd0);
    chk("idle_in_ready", 128'(in_ready), 128'd1);
    @(posedge clk); #1;
  endtask

  initial begin
    int c, c0, hs0;
    logic [127:0] first_issue;
    logic [5:0] pat;
    pat = 6'b101001;
    rst = 1'b1; ctr_load = 1'b0; ctr_init = '0; round_key_0 = '0;
    in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b1;
    model_ctr = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", 128'(in_ready), 128'd1);
    chk("rst_busy", 128'(busy), 128'd0);
    chk("rst_out_valid", 128'(out_valid), 128'd0);
    chk("rst_key_sel", 128'(key_sel), 128'd0);
    chk("rst_pipe_in", pipe_in, 128'd0);
    chk("rst_out_data", out_data, 128'd0);
    @(posedge clk); #1;

    // single block, counter 1, zero whitening key
    ctr_load = 1'b1; ctr_init = 128'd1;
    @(posedge clk); #1;
    ctr_load = 1'b0; model_ctr = 128'd1;
    send(128'd0, 1'b1, c);
    at_cyc(c + 1);
    chk("t1_pipe_in_p1", pipe_in, 128'd1);
    chk("t1_key_sel_p1", 128'(key_sel), 128'd0);
    at_cyc(c + 9);
    chk("t1_key_sel_p2", 128'(key_sel), 128'd1);
    chk("t1_pipe_in_p2", pipe_in, 128'd1 + K1);
    at_cyc(c + 16);
    chk("t1_out_valid_early", 128'(out_valid), 128'd0);
    at_cyc(c + 17);
    chk("t1_out_valid", 128'(out_valid), 128'd1);
    wait_idle();

    // 7 blocks without in_last, counter wraps through 2^128
    round_key_0 = R0;
    ctr_load = 1'b1; ctr_init = {{124{1'b1}}, 4'hE};
    @(posedge clk); #1;
    ctr_load = 1'b0; model_ctr = {{124{1'b1}}, 4'hE};
    for (int k = 0; k < 7; k++) send(128'h100 + 128'(k), 1'b0, c);
    at_cyc(c + 1);
    chk("t2_autoclose_in_ready", 128'(in_ready), 128'd0);
    chk("t2_pipe_in_fe", pipe_in, {{124{1'b1}}, 4'hE} ^ R0);
    at_cyc(c + 3);
    chk("t2_pipe_in_wrap0", pipe_in, R0);
    at_cyc(c + 28);
    chk("t2_out_valid_early", 128'(out_valid), 128'd0);
    at_cyc(c + 29);
    chk("t2_out_valid", 128'(out_valid), 128'd1);
    wait_idle();

    // 5 blocks: key_sel timing, ctr_load ignored in COLLECT and DRAIN
    first_issue = model_ctr ^ R0;
    send(128'h500, 1'b0, c);
    ctr_load = 1'b1; ctr_init = JUNK;
    for (int k = 1; k < 5; k++) send(128'h500 + 128'(k), k == 4, c);
    ctr_load = 1'b0;
    at_cyc(c + 6);
    chk("t4_pipe_in_idle_slot", pipe_in, 128'd0);
    chk("t4_key_sel_hold", 128'(key_sel), 128'd0);
    at_cyc(c + 12);
    chk("t4_key_sel_before", 128'(key_sel), 128'd0);
    chk("t4_pipe_in_flush", pipe_in, 128'd0);
    at_cyc(c + 13);
    chk("t4_key_sel_after", 128'(key_sel), 128'd1);
    chk("t4_pipe_in_p2", pipe_in, first_issue + K1);
    at_cyc(c + 25);
    chk("t4_out_valid", 128'(out_valid), 128'd1);
    ctr_load = 1'b1; ctr_init = JUNK;
    @(posedge clk); #1;
    @(posedge clk); #1;
    ctr_load = 1'b0;
    wait_idle();

    // 3 blocks under back-pressure 1,0,0,1,0,1
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) send(128'h3000 + 128'(k), k == 2, c);
    at_cyc(c + 21);
    chk("t3_out_valid", 128'(out_valid), 128'd1);
    chk("t3_in_ready_drain", 128'(in_ready), 128'd0);
    hs0 = hs_cnt;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      out_ready = pat[k];
      @(negedge clk);
      chk("t3_in_ready_low", 128'(in_ready), 128'd0);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(negedge clk);
    chk("t3_in_ready_after", 128'(in_ready), 128'd1);
    chk("t3_out_valid_drop", 128'(out_valid), 128'd0);
    chk("t3_handshakes", 128'(hs_cnt - hs0), 128'd3);
    @(posedge clk); #1;

    // reset during PASS2 of a 4-block batch
    for (int k = 0; k < 4; k++) send(128'h4000 + 128'(k), k == 3, c);
    at_cyc(c + 14);
    chk("t5_in_pass2", 128'(key_sel), 128'd1);
    rst = 1'b1;
    sb_q.delete();
    model_ctr = '0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("t5_rst_busy", 128'(busy), 128'd0);
    chk("t5_rst_out_valid", 128'(out_valid), 128'd0);
    repeat (30) @(negedge clk);
    @(posedge clk); #1;
    c0 = hs_cnt;
    send(128'h77, 1'b1, c);
    at_cyc(c + 1);
    chk("t5_ctr_cleared", pipe_in, R0);
    wait_idle();
    ctr_load = 1'b1; ctr_init = 128'h10; model_ctr = 128'h10;
    send(128'h88, 1'b1, c);
    ctr_load = 1'b0;
    at_cyc(c + 1);
    chk("t5_load_with_valid", pipe_in, 128'h10 ^ R0);
    wait_idle();
    chk("t5_handshakes", 128'(hs_cnt - c0), 128'd2);
    chk("scoreboard_empty", 128'(sb_q.size()), 128'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec, mis);
    $finish;
  end

endmodule
